// File: rtl/if_stage.sv
// Instruction fetch stage: request/ack handshake to instruction memory, hold-until-consumed output, redirect drain.
// Optional macro IF_STAGE_PERF_EN adds fetch_count / stall_count performance counters.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_write,
  input  logic        PCSrc,
  input  logic [31:0] PC_branch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction_IF,
  output logic [31:0] PC_sumado_IF,
  output logic        fetch_valid
`ifdef IF_STAGE_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {FETCH = 2'd0, WAIT = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic        req_q;
  logic [31:0] br_tgt;

  assign br_tgt    = PC_branch & ~32'h3;
  assign imem_req  = req_q;
  // fetch_addr tracks PC on every entry to FETCH, so it is also the live request address.
  assign imem_addr = fetch_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      fetch_addr     <= RESET_PC;
      req_q          <= 1'b1;
      fetch_valid    <= 1'b0;
      instruction_IF <= NOP_WORD;
      PC_sumado_IF   <= 32'h0;
    end else begin
      case (state)
        FETCH, WAIT: begin
          if (PCSrc) begin
            pc <= br_tgt;
            if (imem_ack) begin
              fetch_addr <= br_tgt;
              state      <= FETCH;
            end else begin
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            instruction_IF <= imem_data;
            PC_sumado_IF   <= fetch_addr + 32'd4;
            fetch_valid    <= 1'b1;
            req_q          <= 1'b0;
            state          <= HOLD;
          end else begin
            state <= WAIT;
          end
        end
        HOLD: begin
          if (PCSrc) begin
            pc             <= br_tgt;
            fetch_addr     <= br_tgt;
            fetch_valid    <= 1'b0;
            instruction_IF <= NOP_WORD;
            req_q          <= 1'b1;
            state          <= FETCH;
          end else if (PC_write) begin
            pc             <= fetch_addr + 32'd4;
            fetch_addr     <= fetch_addr + 32'd4;
            fetch_valid    <= 1'b0;
            instruction_IF <= NOP_WORD;
            req_q          <= 1'b1;
            state          <= FETCH;
          end
        end
        DRAIN: begin
          // Stale request still in flight: wait out its ack, then fetch the redirect target.
          if (PCSrc) begin
            pc <= br_tgt;
          end else if (imem_ack) begin
            fetch_addr <= pc;
            state      <= FETCH;
          end
        end
      endcase
    end
  end

`ifdef IF_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
    end else if (state == HOLD) begin
      if (!PC_write)
        stall_count <= stall_count + 32'd1;
      if (PC_write && !PCSrc)
        fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h00000000, instruction driven when no valid fetch.
REQ-003 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-004 Ports SHALL be exactly:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- PC_write  in  1  hazard-unit enable; 0 = stall, held instruction not consumed
- PCSrc  in  1  taken branch/jump redirect
- PC_branch  in  32  redirect target
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address, word aligned
- imem_ack  in  1  memory data valid; may arrive in the same cycle as imem_req
- imem_data  in  32  fetched word, valid with imem_ack
- instruction_IF  out  32  instruction to IF_ID
- PC_sumado_IF  out  32  fetch address + 4, to IF_ID
- fetch_valid  out  1  instruction_IF holds a real fetched instruction

Function
REQ-005 FSM states SHALL be FETCH, WAIT, HOLD and DRAIN, encoded as 2 bits.
REQ-006 FETCH SHALL drive imem_req=1 and imem_addr=PC, and SHALL latch PC into fetch_addr.
- If imem_ack=0, the next state SHALL be WAIT.
REQ-007 WAIT SHALL hold imem_req=1 with imem_addr=fetch_addr until imem_ack=1.
REQ-008 On imem_ack in FETCH or WAIT with no redirect, the block SHALL register the outputs and enter HOLD:
- instruction_IF<=imem_data
- PC_sumado_IF<=fetch_addr+4
- fetch_valid<=1
REQ-009 HOLD SHALL keep imem_req=0 and SHALL hold the outputs stable while PC_write=0.
REQ-010 In HOLD with PC_write=1 and PCSrc=0, the block SHALL consume the instruction:
- PC<=fetch_addr+4
- fetch_valid<=0
- next state FETCH
REQ-011 Whenever fetch_valid=0, instruction_IF SHALL equal NOP_WORD.
REQ-012 Minimum throughput SHALL be one instruction per 2 cycles with single-cycle ack, and fetch-to-output latency SHALL be 1 cycle after ack.
REQ-013 PCSrc=1 SHALL take priority over PC_write and over imem_ack in every state:
- PC<=PC_branch
- fetch_valid<=0
REQ-014 Redirect destination SHALL depend on the state:
- HOLD: the held instruction is discarded; next state FETCH.
- FETCH or WAIT without ack in the same cycle: next state DRAIN.
- FETCH or WAIT with ack in the same cycle: data discarded; next state FETCH.
REQ-015 DRAIN SHALL keep imem_req=1 at the old fetch_addr until imem_ack, discard imem_data, and then go to FETCH.
REQ-016 A second PCSrc during DRAIN SHALL overwrite PC with the newer PC_branch and remain in DRAIN.
REQ-017 PC+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC+4=0), and bits [1:0] of PC_branch SHALL be forced to 0.

Reset
REQ-018 Reset SHALL set:
- PC=RESET_PC
- fetch_addr=RESET_PC
- state=FETCH
- fetch_valid=0
- instruction_IF=NOP_WORD
- PC_sumado_IF=0
- counters=0
REQ-019 Reset SHALL override all inputs, including a pending ack or redirect.
REQ-020 An ack arriving during reset SHALL be ignored, and no DRAIN state SHALL survive reset.

Configuration
REQ-021 With macro IF_STAGE_PERF_EN defined, the block SHALL add two outputs:
- fetch_count[31:0]: increments on each consumed instruction (REQ-010).
- stall_count[31:0]: increments on each cycle in HOLD with PC_write=0.
- Both counters wrap at 2^32.
REQ-022 Without IF_STAGE_PERF_EN, both ports and their logic SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-023 Reset then 1-cycle ack memory returning addr-based words, PC_write=1 -> fetches at 0,4,8 with PC_sumado_IF 4,8,12, fetch_valid pulsing every 2nd cycle.
REQ-024 Ack delayed 3 cycles -> imem_addr stable at 0x10 for 4 cycles with imem_req=1, fetch_valid=0, instruction_IF=NOP_WORD throughout.
REQ-025 HOLD with PC_write=0 for 5 cycles -> instruction_IF and PC_sumado_IF unchanged, no imem_req, and stall_count=5 when IF_STAGE_PERF_EN is defined.
REQ-026 PCSrc=1, PC_branch=0x100 while in WAIT -> DRAIN until ack, that data dropped, next imem_addr=0x100.
REQ-027 PCSrc=1 with PC_write=1 in HOLD, and also PCSrc with ack in the same cycle -> held or acked word discarded, next fetch at PC_branch.
REQ-028 Reset asserted in WAIT with imem_ack=1 -> next cycle fetch_valid=0 and imem_addr=RESET_PC; also, PC=0xFFFFFFFC consumed -> next fetch at 0.
